// File: rtl/mm_pkg.sv
// -----------------------------------------------------------------------------
// mm_pkg
// Shared types and constants for the matrix-multiply sequencer slice.
//   mm_state_e   : sequencer FSM states (IDLE, RUN, FLUSH, DONE)
//   MM_DIM       : default matrix dimension
//   MM_ADDR_W    : default operand/result buffer address width
//   FLUSH_CYCLES : cycles spent draining the MAC/write pipeline
//   cntWidth()   : width of one loop index for a given dimension
// -----------------------------------------------------------------------------
package mm_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } mm_state_e;

  localparam int MM_DIM       = 4;
  localparam int MM_ADDR_W    = 4;
  localparam int FLUSH_CYCLES = 2;

  function automatic int cntWidth(input int dim);
    return (dim > 1) ? $clog2(dim) : 1;
  endfunction

endpackage

// File: rtl/mm_index_counter.sv
// -----------------------------------------------------------------------------
// mm_index_counter
// Nested i/j/k wrap counter for the matrix-multiply loop nest. k is the
// innermost index, then j, then i.
// Ports:
//   i_clk, i_rst   : clock, asynchronous active-high reset
//   i_en           : advance the counters by one step
//   i_clr          : synchronous clear of all indices (wins over i_en)
//   o_i, o_j, o_k  : current indices
//   o_kLast        : k is at DIM-1
//   o_last         : current triple is (DIM-1, DIM-1, DIM-1)
// -----------------------------------------------------------------------------
module mm_index_counter
  import mm_pkg::*;
#(
  parameter int DIM = MM_DIM
)
(
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_en,
  input  logic                     i_clr,
  output logic [cntWidth(DIM)-1:0] o_i,
  output logic [cntWidth(DIM)-1:0] o_j,
  output logic [cntWidth(DIM)-1:0] o_k,
  output logic                     o_kLast,
  output logic                     o_last
);

  localparam int            CW      = cntWidth(DIM);
  localparam logic [CW-1:0] MAX_IDX = CW'(DIM - 1);
  localparam logic [CW-1:0] ONE     = CW'(1);

  logic [CW-1:0] r_i;
  logic [CW-1:0] r_j;
  logic [CW-1:0] r_k;
  logic          w_jLast;
  logic          w_iLast;

  assign w_jLast = (r_j == MAX_IDX);
  assign w_iLast = (r_i == MAX_IDX);
  assign o_kLast = (r_k == MAX_IDX);
  assign o_last  = o_kLast & w_jLast & w_iLast;
  assign o_i     = r_i;
  assign o_j     = r_j;
  assign o_k     = r_k;

  // The final step wraps every index back to zero, so the counter is
  // already cleared when a run completes normally.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_clr) begin
      r_i <= '0;
      r_j <= '0;
      r_k <= '0;
    end else if (i_en) begin
      if (o_kLast) begin
        r_k <= '0;
        if (w_jLast) begin
          r_j <= '0;
          r_i <= w_iLast ? '0 : r_i + ONE;
        end else begin
          r_j <= r_j + ONE;
        end
      end else begin
        r_k <= r_k + ONE;
      end
    end
  end

endmodule

// File: rtl/mm_sequencer.sv
// -----------------------------------------------------------------------------
// mm_sequencer
// Control FSM for the matrix-multiply datapath computing C = A x B for square
// DIM x DIM matrices. Issues row-major A/B read addresses, drives the MAC
// accumulator one cycle after each issue and writes each result element two
// cycles after its last k was issued.
// Ports:
//   i_clk, i_rst      : clock, asynchronous active-high reset
//   i_start           : begin a multiply (sampled only in IDLE)
//   i_stall           : operands not ready, blocks address issue
//   o_busy            : high in RUN, FLUSH and DONE
//   o_done            : one-cycle pulse after the last result write
//   o_aAddr, o_bAddr  : operand read addresses i*DIM+k, k*DIM+j
//   o_macEn, o_macClr : accumulate / load product (first k of an element)
//   o_cWe, o_cAddr    : result write strobe and address i*DIM+j
//   o_perfCycles      : busy-cycle counter, present only when the macro
//                       MM_SEQ_PERF_CNT_EN is defined
// -----------------------------------------------------------------------------
module mm_sequencer
  import mm_pkg::*;
#(
  parameter int DIM    = MM_DIM,
  parameter int ADDR_W = MM_ADDR_W
)
(
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_stall,
  output logic              o_busy,
  output logic              o_done,
  output logic [ADDR_W-1:0] o_aAddr,
  output logic [ADDR_W-1:0] o_bAddr,
  output logic              o_macEn,
  output logic              o_macClr,
  output logic              o_cWe,
  output logic [ADDR_W-1:0] o_cAddr
`ifdef MM_SEQ_PERF_CNT_EN
  ,
  output logic [15:0]       o_perfCycles
`endif
);

  localparam int                CW         = cntWidth(DIM);
  localparam logic [ADDR_W-1:0] DIM_A      = ADDR_W'(DIM);
  localparam logic [1:0]        FLUSH_LAST = 2'(FLUSH_CYCLES - 1);

  mm_state_e         r_state;
  mm_state_e         w_nextState;
  logic [1:0]        r_flushCnt;

  logic              w_issue;
  logic              w_startAccept;
  logic [CW-1:0]     w_i;
  logic [CW-1:0]     w_j;
  logic [CW-1:0]     w_k;
  logic              w_kLast;
  logic              w_cntLast;
  logic [ADDR_W-1:0] w_iExt;
  logic [ADDR_W-1:0] w_jExt;
  logic [ADDR_W-1:0] w_kExt;
  logic [ADDR_W-1:0] w_cAddrIssue;

  logic              r_s1Valid;
  logic              r_s1Clr;
  logic              r_s1Write;
  logic [ADDR_W-1:0] r_s1CAddr;
  logic              r_s2We;
  logic [ADDR_W-1:0] r_s2CAddr;

  assign w_issue       = (r_state == RUN) & ~i_stall;
  assign w_startAccept = (r_state == IDLE) & i_start;

  mm_index_counter #(
    .DIM (DIM)
  ) u_indexCounter (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_en    (w_issue),
    .i_clr   (w_startAccept),
    .o_i     (w_i),
    .o_j     (w_j),
    .o_k     (w_k),
    .o_kLast (w_kLast),
    .o_last  (w_cntLast)
  );

  // Address arithmetic is done at ADDR_W; the ADDR_W >= clog2(DIM*DIM)
  // constraint guarantees no index ever overflows.
  assign w_iExt       = ADDR_W'(w_i);
  assign w_jExt       = ADDR_W'(w_j);
  assign w_kExt       = ADDR_W'(w_k);
  assign o_aAddr      = w_iExt * DIM_A + w_kExt;
  assign o_bAddr      = w_kExt * DIM_A + w_jExt;
  assign w_cAddrIssue = w_iExt * DIM_A + w_jExt;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_nextState;
    end
  end

  // FLUSH holds for exactly FLUSH_CYCLES cycles regardless of stall.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_flushCnt <= '0;
    end else if (r_state == FLUSH) begin
      r_flushCnt <= r_flushCnt + 2'd1;
    end else begin
      r_flushCnt <= '0;
    end
  end

  always_comb begin
    w_nextState = r_state;
    o_busy      = 1'b1;
    o_done      = 1'b0;
    case (r_state)
      IDLE: begin
        o_busy = 1'b0;
        if (i_start) begin
          w_nextState = RUN;
        end
      end
      RUN: begin
        if (w_issue && w_cntLast) begin
          w_nextState = FLUSH;
        end
      end
      FLUSH: begin
        if (r_flushCnt == FLUSH_LAST) begin
          w_nextState = DONE;
        end
      end
      DONE: begin
        o_done      = 1'b1;
        w_nextState = IDLE;
      end
      default: begin
        w_nextState = IDLE;
      end
    endcase
  end

  // Two-stage pipeline: stage 1 is the MAC cycle, stage 2 the C write.
  // Only the issue stage honours stall; a stalled cycle enters stage 1 as a
  // bubble and the later stages keep moving.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_s1Valid <= 1'b0;
      r_s1Clr   <= 1'b0;
      r_s1Write <= 1'b0;
      r_s1CAddr <= '0;
      r_s2We    <= 1'b0;
      r_s2CAddr <= '0;
    end else begin
      r_s1Valid <= w_issue;
      r_s1Clr   <= w_issue & (w_k == '0);
      r_s1Write <= w_issue & w_kLast;
      r_s1CAddr <= w_cAddrIssue;
      r_s2We    <= r_s1Write;
      if (r_s1Write) begin
        r_s2CAddr <= r_s1CAddr;
      end
    end
  end

  assign o_macEn  = r_s1Valid;
  assign o_macClr = r_s1Clr;
  assign o_cWe    = r_s2We;
  assign o_cAddr  = r_s2CAddr;

`ifdef MM_SEQ_PERF_CNT_EN
  logic [15:0] r_perfCycles;

  // Cleared on an accepted start, counts busy cycles, saturates at all-ones.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_perfCycles <= '0;
    end else if (w_startAccept) begin
      r_perfCycles <= '0;
    end else if (o_busy && (r_perfCycles != 16'hFFFF)) begin
      r_perfCycles <= r_perfCycles + 16'd1;
    end
  end

  assign o_perfCycles = r_perfCycles;
`endif

endmodule
